// File: rtl/fft_bitrev_reorder.sv
// Reorders a bit-reversed serial complex FFT frame into natural order.
// Ping-pong banks let one frame fill while the previous one drains.
module fft_bitrev_reorder #(
    parameter int unsigned INTEGER_SIZE = 6,
    parameter int unsigned FRACT_SIZE   = 12,
    parameter int unsigned NFFT         = 64
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       in_valid,
    input  logic                                       in_start,
    input  logic signed [INTEGER_SIZE+FRACT_SIZE-1:0]  in_r,
    input  logic signed [INTEGER_SIZE+FRACT_SIZE-1:0]  in_i,
    output logic                                       out_valid,
    output logic                                       out_start,
    output logic signed [INTEGER_SIZE+FRACT_SIZE-1:0]  out_r,
    output logic signed [INTEGER_SIZE+FRACT_SIZE-1:0]  out_i,
    output logic        [$clog2(NFFT)-1:0]             out_index,
    output logic                                       frame_err
);

    localparam int unsigned W  = INTEGER_SIZE + FRACT_SIZE;
    localparam int unsigned AW = $clog2(NFFT);
    localparam logic [AW-1:0] LAST = AW'(NFFT - 1);

    typedef enum logic {WIdle, WFill}  wstate_t;
    typedef enum logic {RIdle, RDrain} rstate_t;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int b = 0; b < AW; b++) begin
            r[b] = a[AW-1-b];
        end
        return r;
    endfunction

    logic [2*W-1:0] mem [2*NFFT];

    wstate_t       wstate_q, wstate_d;
    logic [AW-1:0] wcnt_q, wcnt_d;
    logic          wbank_q, wbank_d;
    rstate_t       rstate_q, rstate_d;
    logic [AW-1:0] rcnt_q, rcnt_d;
    logic          rbank_q, rbank_d;
    logic [1:0]    full_q, full_d;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          wr_last;
    logic          abort;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_done;

    always_comb begin
        wstate_d = wstate_q;
        wcnt_d   = wcnt_q;
        wbank_d  = wbank_q;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_last  = 1'b0;
        abort    = 1'b0;
        case (wstate_q)
            WIdle: begin
                if (in_valid && in_start) begin
                    wr_en    = 1'b1;
                    wcnt_d   = AW'(1);
                    wstate_d = WFill;
                end
            end
            WFill: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (in_start) begin
                        // Early start: drop the partial frame, restart in the same bank.
                        abort  = 1'b1;
                        wcnt_d = AW'(1);
                    end else begin
                        wr_addr = bitrev(wcnt_q);
                        wcnt_d  = wcnt_q + AW'(1);
                        if (wcnt_q == LAST) begin
                            wr_last  = 1'b1;
                            wbank_d  = ~wbank_q;
                            wstate_d = WIdle;
                        end
                    end
                end
            end
            default: wstate_d = WIdle;
        endcase
    end

    always_comb begin
        rstate_d = rstate_q;
        rcnt_d   = rcnt_q;
        rbank_d  = rbank_q;
        rd_en    = 1'b0;
        rd_addr  = '0;
        rd_done  = 1'b0;
        case (rstate_q)
            RIdle: begin
                // Address 0 is issued straight from idle so X[0] appears two cycles
                // after the last write.
                if (full_q[rbank_q]) begin
                    rd_en    = 1'b1;
                    rcnt_d   = AW'(1);
                    rstate_d = RDrain;
                end
            end
            RDrain: begin
                rd_en   = 1'b1;
                rd_addr = rcnt_q;
                rcnt_d  = rcnt_q + AW'(1);
                if (rcnt_q == LAST) begin
                    rd_done = 1'b1;
                    rbank_d = ~rbank_q;
                    rcnt_d  = '0;
                    if (!full_q[~rbank_q]) begin
                        rstate_d = RIdle;
                    end
                end
            end
            default: rstate_d = RIdle;
        endcase
    end

    always_comb begin
        full_d = full_q;
        if (rd_done) full_d[rbank_q] = 1'b0;
        if (wr_last) full_d[wbank_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q  <= WIdle;
            wcnt_q    <= '0;
            wbank_q   <= 1'b0;
            rstate_q  <= RIdle;
            rcnt_q    <= '0;
            rbank_q   <= 1'b0;
            full_q    <= '0;
            frame_err <= 1'b0;
        end else begin
            wstate_q  <= wstate_d;
            wcnt_q    <= wcnt_d;
            wbank_q   <= wbank_d;
            rstate_q  <= rstate_d;
            rcnt_q    <= rcnt_d;
            rbank_q   <= rbank_d;
            full_q    <= full_d;
            frame_err <= abort;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wbank_q, wr_addr}] <= {in_r, in_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_start <= 1'b0;
            out_index <= '0;
            out_r     <= '0;
            out_i     <= '0;
        end else begin
            out_valid <= rd_en;
            out_start <= rd_en && (rd_addr == '0);
            out_index <= rd_en ? rd_addr : '0;
            if (rd_en) begin
                {out_r, out_i} <= mem[{rbank_q, rd_addr}];
            end else begin
                out_r <= '0;
                out_i <= '0;
            end
        end
    end

`ifndef SYNTHESIS
    a_no_overrun : assert property (@(posedge clk) disable iff (rst)
        wr_last |-> !full_q[wbank_q]);
`endif

endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
Output reorder buffer for the 64-point radix-2 SDF FFT pipeline. It sits after the last butterfly stage.
- Input: the serial complex stream in bit-reversed index order.
- Output: the same frame in natural order (X[0]..X[NFFT-1]).
- Storage: a ping-pong pair of NFFT-deep complex banks, so it streams one sample per clock continuously.

Parameters:
INTEGER_SIZE, 6, integer bits of each signed fixed-point component
FRACT_SIZE, 12, fractional bits of each component
NFFT, 64, frame length; power of 2, 8..1024

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
in_valid  in  1  qualifies in_r/in_i this cycle
in_start  in  1  marks sample 0 of a frame; meaningful only with in_valid=1
in_r  in  INTEGER_SIZE+FRACT_SIZE  signed real part, bit-reversed order
in_i  in  INTEGER_SIZE+FRACT_SIZE  signed imaginary part
out_valid  out  1  out_r/out_i/out_index valid
out_start  out  1  high with natural index 0
out_r  out  INTEGER_SIZE+FRACT_SIZE  signed real part, natural order
out_i  out  INTEGER_SIZE+FRACT_SIZE  signed imaginary part
out_index  out  log2(NFFT)  natural bin index of current output
frame_err  out  1  one-cycle pulse: frame aborted by early in_start

Behaviour:
- Reset (rst=1 at an edge):
  - all outputs go to 0, both FSMs to IDLE, bank-full flags cleared, write bank = 0, read bank = 0.
  - Memory contents are don't-care.
  - Reset mid-fill or mid-drain discards all data; no partial frame is emitted afterwards.
- Write FSM W_IDLE / W_FILL, counter wcnt of log2(NFFT) bits:
  - W_IDLE: in_valid&in_start writes the sample to address bitrev(0)=0 of the write bank, sets wcnt=1, and goes to W_FILL. in_valid without in_start is dropped.
  - W_FILL: each in_valid writes to address bitrev(wcnt) and increments wcnt. bitrev reverses the log2(NFFT) bits. in_valid=0 cycles are gaps: no write, state held.
  - Last sample (wcnt=NFFT-1 written): set full flag of the write bank, toggle the write bank, return to W_IDLE. An in_start on the very next cycle is accepted (back-to-back frames).
  - in_valid&in_start while in W_FILL: abort the partial frame, pulse frame_err for 1 cycle, restart in the same bank with this sample as sample 0.
- Read FSM R_IDLE / R_DRAIN, counter rcnt:
  - R_IDLE: when the read bank's full flag is set, go to R_DRAIN with rcnt=0.
  - R_DRAIN: read address rcnt sequentially. Memory read is registered, so output lags the address by 1 cycle.
  - After rcnt=NFFT-1: clear that bank's full flag and toggle the read bank. If the other bank is already full, continue directly with rcnt=0 (no bubble); otherwise go to R_IDLE.
- Latency: if a frame's last sample is accepted on cycle t, then out_start with out_index=0 is on cycle t+2. The frame's NFFT outputs occupy cycles t+2..t+NFFT+1 contiguously, with out_valid=1 throughout.
- out_start=1 only with out_index=0. out_valid=0 cycles drive out_r/out_i/out_index=0.
- Overrun cannot occur: input rate is at most 1/clk and drain is exactly NFFT cycles. This invariant is checked by assertion: the write must never complete into a bank whose full flag is set.
- No arithmetic: samples pass bit-exact. Width is INTEGER_SIZE+FRACT_SIZE, with no saturation or rounding.

Test Plan:
- Single frame, NFFT=64: input sample k = (bitrev6(k), -bitrev6(k)), no gaps -> out_r=0..63 and out_i=0..-63 in order; out_index=0..63; out_start once, 2 cycles after the last input.
- Three back-to-back frames, offset by +100 and +200 -> 192 contiguous out_valid cycles, out_start at frame boundaries only, values exact.
- Same frame with in_valid deasserted on every 3rd cycle -> identical natural-order output; first output 2 cycles after the last accepted sample.
- in_start reasserted at sample 20 of a frame, then a full clean frame -> frame_err pulses exactly once, and only the clean frame is emitted.
- rst asserted at output index 30 while the next frame is half written -> all outputs 0 the next cycle; no further out_valid until a new complete frame arrives.
- NFFT=8: input values 0,4,2,6,1,5,3,7 -> output 0..7; signed extremes 0x20000/0x1FFFF pass unchanged.
